leitor_teclado: RTL and testbench

Scans a 4x4 matrix keypad row by row, debounces presses and turns them into game inputs for the battleship console. In PREPARACAO it selects the map. In ATAQUE it collects a column digit and a row digit, then issues a shot on confirm. Its coordColuna, coordLinha and mapa outputs feed the display and game logic directly, with the same 3-bit encoding the display consumes.

---
 rtl/leitor_teclado.sv | 206 ++++++++++++++++++++
 tb/tb_leitor_teclado.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_teclado.sv
// leitor_teclado: row-scanned 4x4 keypad with frame debounce, feeding the
// battleship entry FSM (map selection in preparation, shot coordinates in attack).
module leitor_teclado #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] colunas,
  input  logic       ATAQUE,
  input  logic       PREPARACAO,
  output logic [3:0] linhas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic [2:0] mapa,
  output logic       mapa_confirmado,
  output logic       disparo
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);
  localparam logic [4:0]    NENHUMA   = 5'h10;

  typedef enum logic [1:0] {OCIOSO, ESPERA_COLUNA, ESPERA_LINHA, PRONTO} estado_t;
  typedef enum logic [1:0] {MODO_OFF, MODO_PREP, MODO_ATAQUE} modo_t;

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    col_s1_q, col_s2_q;
  logic [1:0]    samp_q, samp_d;
  logic [1:0]    row_p1_q, row_p2_q;
  logic [15:0]   snap_q, snap_d;
  logic [4:0]    prev_q, prev_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          armado_q, armado_d;
  logic [3:0]    tecla_q, tecla_d;
  logic          valida_q, valida_d;

  estado_t       estado_q, estado_d;
  modo_t         modo_q, modo_d, modo_eff;
  logic [2:0]    col_q, col_d, lin_q, lin_d, mapa_q, mapa_d;
  logic          conf_q, conf_d, disp_q, disp_d;

  logic          slot_last, frame_done, digito, confirma, cancela;
  logic [15:0]   frame;
  logic [4:0]    cand;

  // The sample strobe and row index are delayed two cycles to line up with
  // the synchronized column lines, so each row is read as it was at slot end.
  always_comb begin
    slot_last = (slot_q == SLOT_LAST);
    slot_d    = slot_last ? '0 : slot_q + 1'b1;
    row_d     = slot_last ? row_q + 2'd1 : row_q;
    samp_d    = {samp_q[0], slot_last};

    frame = snap_q;
    if (samp_q[1]) frame[{row_p2_q, 2'b00} +: 4] = ~col_s2_q;
    snap_d     = samp_q[1] ? frame : snap_q;
    frame_done = samp_q[1] && (row_p2_q == 2'd3);

    cand = NENHUMA;
    for (int i = 0; i < 16; i++)
      if (frame[i]) cand = {1'b0, 4'(i)};
    if ($countones(frame) != 1) cand = NENHUMA;

    prev_d   = prev_q;
    cnt_d    = cnt_q;
    armado_d = armado_q;
    tecla_d  = tecla_q;
    valida_d = 1'b0;
    if (frame_done) begin
      prev_d = cand;
      if (cand != prev_q)      cnt_d = DW'(1);
      else if (cnt_q < DEB_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == DEB_MAX) begin
        if (cand == NENHUMA) begin
          armado_d = 1'b1;
        end else if (armado_q) begin
          tecla_d  = cand[3:0];
          valida_d = 1'b1;
          armado_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    if (ATAQUE)          modo_eff = MODO_ATAQUE;
    else if (PREPARACAO) modo_eff = MODO_PREP;
    else                 modo_eff = MODO_OFF;

    digito   = ~tecla_q[3];
    confirma = (tecla_q == 4'd14);
    cancela  = (tecla_q == 4'd15);

    modo_d   = modo_q;
    estado_d = estado_q;
    col_d    = col_q;
    lin_d    = lin_q;
    mapa_d   = mapa_q;
    conf_d   = 1'b0;
    disp_d   = 1'b0;

    // A mode change wins over a key event arriving in the same cycle.
    if (modo_eff != modo_q) begin
      modo_d   = modo_eff;
      estado_d = (modo_eff == MODO_OFF) ? OCIOSO : ESPERA_COLUNA;
    end else if (valida_q) begin
      case (modo_q)
        MODO_PREP: begin
          if (digito)        mapa_d = tecla_q[2:0];
          else if (confirma) conf_d = 1'b1;
          else if (cancela)  mapa_d = 3'd0;
        end
        MODO_ATAQUE: begin
          if (cancela) begin
            col_d    = 3'd0;
            lin_d    = 3'd0;
            estado_d = ESPERA_COLUNA;
          end else begin
            case (estado_q)
              ESPERA_COLUNA: if (digito) begin
                col_d    = tecla_q[2:0];
                estado_d = ESPERA_LINHA;
              end
              ESPERA_LINHA: if (digito) begin
                lin_d    = tecla_q[2:0];
                estado_d = PRONTO;
              end
              PRONTO: begin
                if (digito) begin
                  lin_d = tecla_q[2:0];
                end else if (confirma) begin
                  disp_d   = 1'b1;
                  estado_d = ESPERA_COLUNA;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q   <= '0;
      row_q    <= 2'd0;
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      samp_q   <= 2'b00;
      row_p1_q <= 2'd0;
      row_p2_q <= 2'd0;
      snap_q   <= '0;
      prev_q   <= NENHUMA;
      cnt_q    <= '0;
      armado_q <= 1'b1;
      tecla_q  <= 4'd0;
      valida_q <= 1'b0;
      modo_q   <= MODO_OFF;
      estado_q <= OCIOSO;
      col_q    <= 3'd0;
      lin_q    <= 3'd0;
      mapa_q   <= 3'd0;
      conf_q   <= 1'b0;
      disp_q   <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      row_q    <= row_d;
      col_s1_q <= colunas;
      col_s2_q <= col_s1_q;
      samp_q   <= samp_d;
      row_p1_q <= row_q;
      row_p2_q <= row_p1_q;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      armado_q <= armado_d;
      tecla_q  <= tecla_d;
      valida_q <= valida_d;
      modo_q   <= modo_d;
      estado_q <= estado_d;
      col_q    <= col_d;
      lin_q    <= lin_d;
      mapa_q   <= mapa_d;
      conf_q   <= conf_d;
      disp_q   <= disp_d;
    end
  end

  assign linhas          = ~(4'b0001 << row_q);
  assign tecla           = tecla_q;
  assign tecla_valida    = valida_q;
  assign coordColuna     = col_q;
  assign coordLinha      = lin_q;
  assign mapa            = mapa_q;
  assign mapa_confirmado = conf_q;
  assign disparo         = disp_q;

endmodule

// File: tb/tb_leitor_teclado.sv
// tb_leitor_teclado: directed and randomized keypad sessions compared against a
// frame-level model of debounce and game entry.
module tb_leitor_teclado;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] colunas;
  logic       ATAQUE, PREPARACAO;
  logic [3:0] linhas, tecla;
  logic       tecla_valida, mapa_confirmado, disparo;
  logic [2:0] coordColuna, coordLinha, mapa;

  int checks = 0;
  int errors = 0;
  logic [15:0] keys = '0;

  leitor_teclado #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock(clock), .reset(reset), .colunas(colunas),
    .ATAQUE(ATAQUE), .PREPARACAO(PREPARACAO), .linhas(linhas),
    .tecla(tecla), .tecla_valida(tecla_valida),
    .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
    .mapa_confirmado(mapa_confirmado), .disparo(disparo)
  );

  always #5 clock = ~clock;

  // Passive keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    colunas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!linhas[r] && keys[4*r+c]) colunas[c] = 1'b0;
  end

  int frameCount = 0, validCount = 0, shotCount = 0, confCount = 0;
  logic [3:0] prevLinhas = 4'hF;
  logic [2:0] shotCol = '0, shotLin = '0;

  always @(negedge clock) begin
    if (!reset && linhas == 4'b1110 && prevLinhas == 4'b0111) frameCount++;
    prevLinhas = linhas;
    if (tecla_valida) validCount++;
    if (mapa_confirmado) confCount++;
    if (disparo) begin
      shotCount++;
      shotCol = coordColuna;
      shotLin = coordLinha;
    end
  end

  // Reference model state
  int hist[$];
  int pend[$];
  bit mArmed = 1'b1;
  bit lastAccept = 1'b0;
  int modeled = 0;
  int expValid = 0, expTecla = 0;
  int mMode = 0, mPhase = 0, expCol = 0, expLin = 0, expMapa = 0;
  int expShots = 0, expConfs = 0, expShotCol = 0, expShotLin = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic modelFrame(input logic [15:0] k);
    int cand, run;
    cand = -1;
    if ($countones(k) == 1)
      for (int i = 0; i < 16; i++) if (k[i]) cand = i;
    hist.push_back(cand);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == cand; i--) run++;
    if (cand >= 0 && run >= DEBOUNCE && mArmed) begin
      expValid++;
      expTecla = cand;
      mArmed = 1'b0;
      pend.push_back(cand);
    end
    if (cand < 0 && run >= DEBOUNCE) mArmed = 1'b1;
  endtask

  task automatic applyKey(input int code);
    if (mMode == 1) begin
      if (code < 8) expMapa = code;
      else if (code == 14) expConfs++;
      else if (code == 15) expMapa = 0;
    end else if (mMode == 2) begin
      if (code == 15) begin
        expCol = 0; expLin = 0; mPhase = 0;
      end else if (code < 8) begin
        if (mPhase == 0) begin expCol = code; mPhase = 1; end
        else begin expLin = code; mPhase = 2; end
      end else if (code == 14 && mPhase == 2) begin
        expShots++; expShotCol = expCol; expShotLin = expLin; mPhase = 0;
      end
    end
  endtask

  task automatic setMode(input logic a, input logic p);
    int m;
    ATAQUE = a;
    PREPARACAO = p;
    m = a ? 2 : (p ? 1 : 0);
    if (m != mMode) begin
      mMode = m;
      mPhase = 0;
    end
  endtask

  // Waits for each frame boundary, models the frame just finished, then
  // presents the next key pattern for the whole new frame.
  task automatic applyStimulus(input logic [15:0] k, input int nFrames, input bit dropKeys);
    for (int f = 0; f < nFrames; f++) begin
      for (int t = 0; t < 40 && frameCount == modeled; t++) begin
        @(negedge clock);
        #1;
      end
      if (frameCount == modeled) checkOutput("frame_timeout", 32'd0, 32'd1);
      while (modeled < frameCount) begin
        modelFrame(keys);
        modeled++;
      end
      lastAccept = (pend.size() > 0);
      while (pend.size() > 0) begin
        int c;
        c = pend.pop_front();
        if (!dropKeys) applyKey(c);
      end
      keys = k;
    end
  endtask

  task automatic pressKey(input int code);
    applyStimulus(16'(1) << code, DEBOUNCE, 1'b0);
    applyStimulus(16'h0000, DEBOUNCE, 1'b0);
  endtask

  task automatic checkState(input string tag);
    repeat (6) @(negedge clock);
    checkOutput({tag, "_pulses"}, validCount, expValid);
    checkOutput({tag, "_tecla"}, tecla, expTecla);
    checkOutput({tag, "_col"}, coordColuna, expCol);
    checkOutput({tag, "_lin"}, coordLinha, expLin);
    checkOutput({tag, "_mapa"}, mapa, expMapa);
    checkOutput({tag, "_shots"}, shotCount, expShots);
    checkOutput({tag, "_confs"}, confCount, expConfs);
  endtask

  task automatic resetModel();
    hist.delete();
    pend.delete();
    mArmed = 1'b1;
    expTecla = 0; expCol = 0; expLin = 0; expMapa = 0; mPhase = 0;
    mMode = ATAQUE ? 2 : (PREPARACAO ? 1 : 0);
    modeled = frameCount;
  endtask

  initial begin
    logic [3:0] expLinhas;
    logic [15:0] k;
    int kind, m;
    bit seen;

    reset = 1'b1; ATAQUE = 1'b0; PREPARACAO = 1'b0; keys = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_linhas", linhas, 4'b1110);
    checkOutput("reset_tecla", tecla, 0);
    checkOutput("reset_valida", tecla_valida, 0);
    checkOutput("reset_outs", {coordColuna, coordLinha, mapa, mapa_confirmado, disparo}, 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      expLinhas = ~(4'b0001 << (i / 4));
      checkOutput("linhas_scan", linhas, expLinhas);
      @(negedge clock);
    end
    #1;
    checkOutput("idle_no_pulses", validCount + shotCount + confCount, 0);

    // Held key 6 gives one pulse; release and press again gives a second
    applyStimulus(16'(1) << 6, 10, 1'b0);
    applyStimulus(16'h0000, 3, 1'b0);
    checkState("hold6");
    checkOutput("hold6_one_pulse", validCount, 1);
    applyStimulus(16'(1) << 6, 4, 1'b0);
    applyStimulus(16'h0000, 3, 1'b0);
    checkState("repress6");

    // Bounce and two-key ghosting are rejected
    applyStimulus(16'(1) << 6, 2, 1'b0);
    applyStimulus(16'h0000, 1, 1'b0);
    applyStimulus(16'(1) << 6, 2, 1'b0);
    applyStimulus(16'h0000, 3, 1'b0);
    applyStimulus(16'h0006, 5, 1'b0);
    applyStimulus(16'h0000, 3, 1'b0);
    checkState("bounce_ghost");
    checkOutput("bounce_ghost_count", validCount, 2);

    // Attack: column, row, confirm
    setMode(1'b1, 1'b0);
    pressKey(3); pressKey(5); pressKey(14);
    checkState("shot");
    checkOutput("shot_col", shotCol, expShotCol);
    checkOutput("shot_lin", shotLin, expShotLin);
    checkOutput("shot_col_fixed", coordColuna, 3);
    pressKey(4); pressKey(15);
    checkState("cancel");
    pressKey(2); pressKey(14);
    checkState("confirm_ignored");

    // Preparation: map then confirm, then a mode switch that drops a key
    setMode(1'b0, 1'b1);
    pressKey(7); pressKey(14);
    checkState("prep");
    applyStimulus(16'(1) << 5, DEBOUNCE, 1'b0);
    applyStimulus(16'h0000, 1, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      if (tecla_valida) seen = 1'b1;
      else @(negedge clock);
    end
    checkOutput("drop_pulse_seen", seen, 1);
    setMode(1'b1, 1'b0);
    applyStimulus(16'h0000, 2, 1'b0);
    checkState("drop");
    checkOutput("drop_mapa_kept", mapa, 7);
    pressKey(6);
    checkState("after_drop");

    // Randomized sessions
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 9);
      k = '0;
      if (kind >= 2 && kind <= 8) k[$urandom_range(0, 15)] = 1'b1;
      else if (kind == 9) begin
        k[$urandom_range(0, 7)] = 1'b1;
        k[$urandom_range(8, 15)] = 1'b1;
      end
      applyStimulus(k, $urandom_range(1, 5), 1'b0);
      applyStimulus(16'h0000, $urandom_range(1, 4), 1'b0);
      if (!lastAccept && $urandom_range(0, 4) == 0) begin
        m = $urandom_range(0, 3);
        setMode(m[1], m[0]);
      end
      checkState("rand");
    end

    // Reset in the middle of an attack entry
    setMode(1'b1, 1'b0);
    applyStimulus(16'h0000, DEBOUNCE, 1'b0);
    pressKey(3);
    applyStimulus(16'(1) << 4, 2, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_linhas", linhas, 4'b1110);
    checkOutput("midreset_tecla", tecla, 0);
    checkOutput("midreset_outs", {tecla_valida, coordColuna, coordLinha, mapa, mapa_confirmado, disparo}, 0);
    @(negedge clock);
    reset = 1'b0;
    resetModel();
    applyStimulus(16'(1) << 4, DEBOUNCE, 1'b0);
    applyStimulus(16'h0000, DEBOUNCE, 1'b0);
    checkState("after_reset");
    checkOutput("after_reset_col", coordColuna, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
